// File: rtl/alu_ctrl_pkg.sv
// Shared constants and small helpers for the ID/EX ALU control stage.
// Optional build macro ALU_DEC_ILLEGAL_FLAG_EN enables the illegal-encoding flag.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_SLL   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SRL   = 4'b0100;
    localparam logic [3:0] ALU_SRA   = 4'b0101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_PASSB = 4'b1000;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] SLT_NONE = 2'b00;
    localparam logic [1:0] SLT_S    = 2'b01;
    localparam logic [1:0] SLT_U    = 2'b10;

    typedef struct packed {
        logic [3:0] alu;
        logic [1:0] slt;
    } arith_t;

    // Comparisons run on the subtractor; EX post-processes the result using slt.
    function automatic arith_t arith_op(input logic [2:0] funct3, input logic alt);
        arith_t r;
        r.slt = SLT_NONE;
        case (funct3)
            3'b000:  r.alu = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r.alu = ALU_SLL;
            3'b010:  begin r.alu = ALU_SUB; r.slt = SLT_S; end
            3'b011:  begin r.alu = ALU_SUB; r.slt = SLT_U; end
            3'b100:  r.alu = ALU_XOR;
            3'b101:  r.alu = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r.alu = ALU_OR;
            default: r.alu = ALU_AND;
        endcase
        return r;
    endfunction

    function automatic logic bad_funct7(input logic [6:0] funct7, input logic [2:0] funct3);
        return (|{funct7[6], funct7[4:0]}) ||
               (funct7[5] && (funct3 != 3'b000) && (funct3 != 3'b101));
    endfunction

endpackage

// File: rtl/alu_dec.sv
// Combinational RV32I decode into ALU opcode, operand selects and immediate.
// With ALU_DEC_ILLEGAL_FLAG_EN defined, also flags unknown opcodes and bad funct7.
module alu_dec
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] instr,
    output logic [3:0]      alu_ctrl,
    output logic            a_sel,
    output logic            b_sel,
    output logic [XLEN-1:0] imm,
    output logic [1:0]      slt_sel,
    output logic            illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    arith_t     op;

    logic signed [XLEN-1:0] imm_i;
    logic signed [XLEN-1:0] imm_s;
    logic signed [XLEN-1:0] imm_b;
    logic signed [XLEN-1:0] imm_u;
    logic signed [XLEN-1:0] imm_j;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign imm_i = XLEN'($signed(instr[31:20]));
    assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

    always_comb begin
        alu_ctrl = ALU_ADD;
        a_sel    = 1'b0;
        b_sel    = 1'b0;
        imm      = '0;
        slt_sel  = SLT_NONE;
        op       = arith_op(funct3, 1'b0);
        case (opcode)
            OPC_OP: begin
                op       = arith_op(funct3, funct7[5]);
                alu_ctrl = op.alu;
                slt_sel  = op.slt;
            end
            // Only SRAI looks at funct7[5]; an ADDI with bit 30 set stays ADD.
            OPC_OPIMM: begin
                op       = arith_op(funct3, funct7[5] && (funct3 == 3'b101));
                alu_ctrl = op.alu;
                slt_sel  = op.slt;
                b_sel    = 1'b1;
                imm      = imm_i;
            end
            OPC_LUI: begin
                alu_ctrl = ALU_PASSB;
                b_sel    = 1'b1;
                imm      = imm_u;
            end
            OPC_AUIPC: begin
                a_sel = 1'b1;
                b_sel = 1'b1;
                imm   = imm_u;
            end
            OPC_JAL: begin
                a_sel = 1'b1;
                b_sel = 1'b1;
                imm   = imm_j;
            end
            OPC_JALR, OPC_LOAD: begin
                b_sel = 1'b1;
                imm   = imm_i;
            end
            OPC_STORE: begin
                b_sel = 1'b1;
                imm   = imm_s;
            end
            OPC_BRANCH: begin
                alu_ctrl = ALU_SUB;
                imm      = imm_b;
            end
            default: ;
        endcase
    end

`ifdef ALU_DEC_ILLEGAL_FLAG_EN
    always_comb begin
        illegal = 1'b0;
        case (opcode)
            OPC_OP:    illegal = bad_funct7(funct7, funct3);
            OPC_OPIMM: illegal = ((funct3 == 3'b001) || (funct3 == 3'b101)) &&
                                 bad_funct7(funct7, funct3);
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
            OPC_LOAD, OPC_STORE, OPC_BRANCH: illegal = 1'b0;
            default:   illegal = 1'b1;
        endcase
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/alu_ctrl_stage.sv
// ID/EX pipeline register for ALU controls: reset > flush > stall > load priority.
// Illegal_o is live only when built with ALU_DEC_ILLEGAL_FLAG_EN.
module alu_ctrl_stage
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            Clk_i,
    input  logic            Rst_i,
    input  logic [XLEN-1:0] Instr_i,
    input  logic            Valid_i,
    input  logic            Stall_i,
    input  logic            Flush_i,
    output logic [3:0]      ALUCtrl_o,
    output logic            ASel_o,
    output logic            BSel_o,
    output logic [XLEN-1:0] Imm_o,
    output logic [1:0]      SltSel_o,
    output logic            Valid_o,
    output logic            Illegal_o
);

    logic [3:0]      alu_p0;
    logic            a_sel_p0;
    logic            b_sel_p0;
    logic [XLEN-1:0] imm_p0;
    logic [1:0]      slt_p0;
    logic            illegal_p0;

    alu_dec #(.XLEN(XLEN)) u_dec (
        .instr    (Instr_i),
        .alu_ctrl (alu_p0),
        .a_sel    (a_sel_p0),
        .b_sel    (b_sel_p0),
        .imm      (imm_p0),
        .slt_sel  (slt_p0),
        .illegal  (illegal_p0)
    );

    // Decode -> EX boundary; a bubble is all-zero fields.
    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i || (!Rst_i && Flush_i)) begin
            ALUCtrl_o <= ALU_ADD;
            ASel_o    <= 1'b0;
            BSel_o    <= 1'b0;
            Imm_o     <= '0;
            SltSel_o  <= SLT_NONE;
            Valid_o   <= 1'b0;
            Illegal_o <= 1'b0;
        end else if (!Stall_i) begin
            Valid_o <= Valid_i;
            if (Valid_i) begin
                ALUCtrl_o <= alu_p0;
                ASel_o    <= a_sel_p0;
                BSel_o    <= b_sel_p0;
                Imm_o     <= imm_p0;
                SltSel_o  <= slt_p0;
                Illegal_o <= illegal_p0;
            end else begin
                ALUCtrl_o <= ALU_ADD;
                ASel_o    <= 1'b0;
                BSel_o    <= 1'b0;
                Imm_o     <= '0;
                SltSel_o  <= SLT_NONE;
                Illegal_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: directed cases plus randomized traffic against a reference decoder.
// Expectations for Illegal_o follow the ALU_DEC_ILLEGAL_FLAG_EN build macro.
module tb_alu_ctrl_stage;

`ifdef ALU_DEC_ILLEGAL_FLAG_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  alu;
        logic        asel;
        logic        bsel;
        logic [31:0] imm;
        logic [1:0]  slt;
        logic        vld;
        logic        ill;
    } exp_t;

    typedef struct {
        exp_t  e;
        string nm;
    } item_t;

    logic        Clk_i = 1'b0;
    logic        Rst_i = 1'b1;
    logic [31:0] Instr_i = '0;
    logic        Valid_i = 1'b0;
    logic        Stall_i = 1'b0;
    logic        Flush_i = 1'b0;
    logic [3:0]  ALUCtrl_o;
    logic        ASel_o;
    logic        BSel_o;
    logic [31:0] Imm_o;
    logic [1:0]  SltSel_o;
    logic        Valid_o;
    logic        Illegal_o;

    int    n_checks = 0;
    int    n_fail   = 0;
    item_t sb[$];
    exp_t  cur = '0;

    alu_ctrl_stage #(.XLEN(32)) dut (
        .Clk_i     (Clk_i),
        .Rst_i     (Rst_i),
        .Instr_i   (Instr_i),
        .Valid_i   (Valid_i),
        .Stall_i   (Stall_i),
        .Flush_i   (Flush_i),
        .ALUCtrl_o (ALUCtrl_o),
        .ASel_o    (ASel_o),
        .BSel_o    (BSel_o),
        .Imm_o     (Imm_o),
        .SltSel_o  (SltSel_o),
        .Valid_o   (Valid_o),
        .Illegal_o (Illegal_o)
    );

    always #5 Clk_i = ~Clk_i;

    function automatic exp_t mk(input logic [3:0] a, input logic as, input logic bs,
                                input logic [31:0] im, input logic [1:0] sl,
                                input logic v, input logic il);
        exp_t e;
        e.alu = a; e.asel = as; e.bsel = bs; e.imm = im; e.slt = sl; e.vld = v; e.ill = il;
        return e;
    endfunction

    // Reference decoder built from the instruction-set rules with integer arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic v);
        exp_t       e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        int         ii, ss, bb, jj, uu;
        bit         isimm, alt, shift;
        e = '0;
        e.vld = v;
        if (!v) return e;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        ii  = (ins[31] ? -2048 : 0) + int'(ins[30:20]);
        ss  = (ins[31] ? -2048 : 0) + int'(ins[30:25]) * 32 + int'(ins[11:7]);
        bb  = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        jj  = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        uu  = int'(ins[31:12]) * 4096;
        case (opc)
            7'h33, 7'h13: begin
                isimm = (opc == 7'h13);
                alt   = ins[30] && (!isimm || f3 == 3'd5);
                case (f3)
                    3'd0: e.alu = alt ? 4'd1 : 4'd0;
                    3'd1: e.alu = 4'd2;
                    3'd2: begin e.alu = 4'd1; e.slt = 2'd1; end
                    3'd3: begin e.alu = 4'd1; e.slt = 2'd2; end
                    3'd4: e.alu = 4'd3;
                    3'd5: e.alu = alt ? 4'd5 : 4'd4;
                    3'd6: e.alu = 4'd6;
                    default: e.alu = 4'd7;
                endcase
                e.bsel = isimm;
                e.imm  = isimm ? ii : 0;
                shift  = !isimm || f3 == 3'd1 || f3 == 3'd5;
                e.ill  = ILL_EN && shift &&
                         (((f7 & 7'h5F) != 0) || (f7[5] && f3 != 3'd0 && f3 != 3'd5));
            end
            7'h37: begin e.alu = 4'd8; e.bsel = 1'b1; e.imm = uu; end
            7'h17: begin e.asel = 1'b1; e.bsel = 1'b1; e.imm = uu; end
            7'h6F: begin e.asel = 1'b1; e.bsel = 1'b1; e.imm = jj; end
            7'h67, 7'h03: begin e.bsel = 1'b1; e.imm = ii; end
            7'h23: begin e.bsel = 1'b1; e.imm = ss; end
            7'h63: begin e.alu = 4'd1; e.imm = bb; end
            default: e.ill = ILL_EN;
        endcase
        return e;
    endfunction

    task automatic chk(input string nm, input exp_t e);
        exp_t a;
        a.alu = ALUCtrl_o; a.asel = ASel_o; a.bsel = BSel_o; a.imm = Imm_o;
        a.slt = SltSel_o; a.vld = Valid_o; a.ill = Illegal_o;
        n_checks++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got alu=%h asel=%b bsel=%b imm=%h slt=%b vld=%b ill=%b, want alu=%h asel=%b bsel=%b imm=%h slt=%b vld=%b ill=%b",
                     nm, a.alu, a.asel, a.bsel, a.imm, a.slt, a.vld, a.ill,
                     e.alu, e.asel, e.bsel, e.imm, e.slt, e.vld, e.ill);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic v, input logic s, input logic f);
        @(posedge Clk_i);
        #2;
        Instr_i = ins; Valid_i = v; Stall_i = s; Flush_i = f;
    endtask

    task automatic step_exp(input string nm, input logic [31:0] ins, input logic v,
                            input logic s, input logic f, input exp_t e);
        item_t it;
        drive(ins, v, s, f);
        cur = e;
        it.e = e; it.nm = nm;
        sb.push_back(it);
    endtask

    task automatic step_model(input string nm, input logic [31:0] ins, input logic v,
                              input logic s, input logic f);
        item_t it;
        drive(ins, v, s, f);
        if (f)       cur = '0;
        else if (!s) cur = ref_decode(ins, v);
        it.e = cur; it.nm = nm;
        sb.push_back(it);
    endtask

    // Monitor: every edge with a pending expectation is checked just after it.
    initial begin
        item_t it;
        forever begin
            @(posedge Clk_i);
            #1;
            if (sb.size() > 0) begin
                it = sb.pop_front();
                chk(it.nm, it.e);
            end
        end
    end

    localparam logic [6:0] OPCS [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F,
                                         7'h67, 7'h03, 7'h23, 7'h63, 7'h7F};

    initial begin
        logic [31:0] ins;
        logic [6:0]  opc;
        exp_t        e_add;
        exp_t        zero;
        item_t       it;
        zero  = '0;
        e_add = mk(4'd0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0);

        repeat (2) @(posedge Clk_i);
        #1;
        chk("reset_state", zero);
        Rst_i = 1'b0;

        step_exp("add",        32'h002081B3, 1'b1, 1'b0, 1'b0, e_add);
        step_exp("sub",        32'h402081B3, 1'b1, 1'b0, 1'b0, mk(4'd1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0));
        step_exp("srai",       32'h40335293, 1'b1, 1'b0, 1'b0, mk(4'd5, 1'b0, 1'b1, 32'h403, 2'd0, 1'b1, 1'b0));
        step_exp("addi_b30",   32'h40008093, 1'b1, 1'b0, 1'b0, mk(4'd0, 1'b0, 1'b1, 32'h400, 2'd0, 1'b1, 1'b0));
        step_exp("lui",        32'h123450B7, 1'b1, 1'b0, 1'b0, mk(4'd8, 1'b0, 1'b1, 32'h12345000, 2'd0, 1'b1, 1'b0));
        step_exp("auipc",      32'h12345097, 1'b1, 1'b0, 1'b0, mk(4'd0, 1'b1, 1'b1, 32'h12345000, 2'd0, 1'b1, 1'b0));
        step_exp("slt",        32'h0020A1B3, 1'b1, 1'b0, 1'b0, mk(4'd1, 1'b0, 1'b0, 32'h0, 2'd1, 1'b1, 1'b0));
        step_exp("sltiu",      32'hFFF0B193, 1'b1, 1'b0, 1'b0, mk(4'd1, 1'b0, 1'b1, 32'hFFFFFFFF, 2'd2, 1'b1, 1'b0));
        step_exp("beq_m4",     32'hFE000EE3, 1'b1, 1'b0, 1'b0, mk(4'd1, 1'b0, 1'b0, 32'hFFFFFFFC, 2'd0, 1'b1, 1'b0));
        step_exp("invalid",    32'h402081B3, 1'b0, 1'b0, 1'b0, zero);

        step_exp("add_load",   32'h002081B3, 1'b1, 1'b0, 1'b0, e_add);
        step_exp("stall1",     32'h123450B7, 1'b1, 1'b1, 1'b0, e_add);
        step_exp("stall2",     32'h40335293, 1'b0, 1'b1, 1'b0, e_add);
        step_exp("stall3",     32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, e_add);
        step_exp("stall_flush", 32'h402081B3, 1'b1, 1'b1, 1'b1, zero);

        step_exp("sub_load",   32'h402081B3, 1'b1, 1'b0, 1'b0, mk(4'd1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0));
        step_exp("stall_pre",  32'h123450B7, 1'b1, 1'b1, 1'b0, mk(4'd1, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0));
        // Asynchronous reset pulse between edges while the stage is stalled.
        @(posedge Clk_i);
        #2;
        Instr_i = 32'h123450B7; Valid_i = 1'b1; Stall_i = 1'b1; Flush_i = 1'b0;
        Rst_i = 1'b1;
        #1;
        chk("async_reset", zero);
        Rst_i = 1'b0;
        cur = '0;
        it.e = cur; it.nm = "stall_after_rst";
        sb.push_back(it);
        step_exp("lui_after_rst", 32'h123450B7, 1'b1, 1'b0, 1'b0, mk(4'd8, 1'b0, 1'b1, 32'h12345000, 2'd0, 1'b1, 1'b0));

        step_exp("unknown_opc", 32'h0000007F, 1'b1, 1'b0, 1'b0, mk(4'd0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1, ILL_EN));
        step_model("bad_f7_op",   32'h042081B3, 1'b1, 1'b0, 1'b0);
        step_model("bad_f7_slli", 32'h40209093, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            opc = OPCS[$urandom_range(0, 9)];
            if (opc == 7'h7F) opc = 7'($urandom_range(0, 127));
            ins[6:0] = opc;
            if ($urandom_range(0, 1) == 0) ins[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
            step_model("random", ins, ($urandom_range(0, 9) != 0),
                       ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
        end

        repeat (2) @(posedge Clk_i);
        #3;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
